ni_inject0: RTL

NI_INJECT0 -- requirements
Module: ni_inject0

---
 rtl/ni_inject0.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ni_inject0.sv
// ni_inject0 -- network-interface injection port for a 4x4 mesh node.
// Turns a request (dest, len) plus len+1 payload beats into a
// header / body / tail flit train for the router local input, under
// credit-based flow control against the downstream input buffer.
// Optional build macro: NI_SELF_DROP_EN -- requests addressed to this
// node are swallowed in IDLE and reported with a one-cycle drop pulse.
module ni_inject0 #(
    parameter int X_S_ADDR     = 1,
    parameter int Y_S_ADDR     = 2,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_dest_x,
    input  logic [1:0] req_dest_y,
    input  logic [1:0] req_len,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [5:0] data_in,
    output logic [7:0] flit_out,
    output logic       flit_valid,
    input  logic       credit_in,
    output logic       pkt_done,
    output logic       drop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_TAIL = 2'd3;

    localparam logic [2:0] CRED_MAX = 3'(CREDIT_DEPTH);
    localparam logic [1:0] SELF_X   = 2'(X_S_ADDR);
    localparam logic [1:0] SELF_Y   = 2'(Y_S_ADDR);

    logic [1:0] state_q, state_d;
    logic [2:0] credit_q, credit_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] dx_q, dx_d, dy_q, dy_d, len_q, len_d;
    logic [7:0] flit_q, flit_d;
    logic       fv_q, fv_d;
    logic       done_q, done_d;
    logic       send, cred_ok, xfer, self_hit;

    assign cred_ok    = (credit_q != 3'd0);
    assign req_ready  = (state_q == S_IDLE);
    assign data_ready = ((state_q == S_BODY) || (state_q == S_TAIL)) && cred_ok;
    assign xfer       = data_valid && data_ready;
    assign self_hit   = (req_dest_x == SELF_X) && (req_dest_y == SELF_Y);

    assign flit_out   = flit_q;
    assign flit_valid = fv_q;
    assign pkt_done   = done_q;

`ifdef NI_SELF_DROP_EN
    logic drop_q, drop_d;
    assign drop = drop_q;
`else
    // Self-addressed requests travel like any other; the compare is unused.
    logic unused_self;
    assign unused_self = self_hit;
    assign drop        = 1'b0;
`endif

    // Packet sequencer: accept request, then emit header, bodies, tail.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        len_d   = len_q;
        flit_d  = flit_q;
        fv_d    = 1'b0;
        done_d  = 1'b0;
        send    = 1'b0;
`ifdef NI_SELF_DROP_EN
        drop_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    dx_d  = req_dest_x;
                    dy_d  = req_dest_y;
                    len_d = req_len;
                    cnt_d = req_len;
`ifdef NI_SELF_DROP_EN
                    if (self_hit) drop_d  = 1'b1;
                    else          state_d = S_HEAD;
`else
                    state_d = S_HEAD;
`endif
                end
            end
            S_HEAD: begin
                if (cred_ok) begin
                    send    = 1'b1;
                    fv_d    = 1'b1;
                    flit_d  = {2'b10, len_q, dy_q, dx_q};
                    state_d = (len_q != 2'd0) ? S_BODY : S_TAIL;
                end
            end
            S_BODY: begin
                if (xfer) begin
                    send   = 1'b1;
                    fv_d   = 1'b1;
                    flit_d = {2'b00, data_in};
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = S_TAIL;
                end
            end
            default: begin
                if (xfer) begin
                    send    = 1'b1;
                    fv_d    = 1'b1;
                    done_d  = 1'b1;
                    flit_d  = {2'b01, data_in};
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Credit bookkeeping: a send and a returned credit in the same cycle cancel.
    always_comb begin
        credit_d = credit_q;
        if (send && !credit_in)
            credit_d = credit_q - 3'd1;
        else if (!send && credit_in && (credit_q != CRED_MAX))
            credit_d = credit_q + 3'd1;
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            credit_q <= CRED_MAX;
            cnt_q    <= 2'd0;
            dx_q     <= 2'd0;
            dy_q     <= 2'd0;
            len_q    <= 2'd0;
            flit_q   <= 8'h00;
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            len_q    <= len_d;
            flit_q   <= flit_d;
            fv_q     <= fv_d;
            done_q   <= done_d;
        end
    end

`ifdef NI_SELF_DROP_EN
    // Drop pulse register for swallowed self-addressed requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= drop_d;
    end
`endif

endmodule
